// File: rtl/vram_stream_loader_m_pkg.sv
// gpu_loader_pkg: shared types and constants for the VRAM stream loader.
//   - state_e       : packet parser states (S_CSUM only with VRAM_LOADER_CHECKSUM_EN)
//   - DEF_SYNC_BYTE : default packet start marker
//   - HDR_BYTES     : header bytes following the sync byte
//   - VRAM_SIZE_C / VRAM_AW : VRAM geometry from the shared VRAM_SIZE /
//     VRAM_ADDR_WIDTH macros; fallbacks apply only when the shared header
//     has not defined them.
// Optional feature macro: VRAM_LOADER_CHECKSUM_EN.
`ifndef VRAM_SIZE
`define VRAM_SIZE 32'h900
`endif
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

package gpu_loader_pkg;

  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
  localparam int unsigned HDR_BYTES     = 4;
  localparam int unsigned VRAM_SIZE_C   = `VRAM_SIZE;
  localparam int unsigned VRAM_AW       = `VRAM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
`ifdef VRAM_LOADER_CHECKSUM_EN
    S_DATA,
    S_CSUM
`else
    S_DATA
`endif
  } state_e;

  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/vram_stream_loader_m_if.sv
// vram_stream_loader_if: host byte stream plus VRAM write port.
//   host side : in_data, in_valid -> loader; in_ready <- loader
//   GPU side  : write_allow -> loader; data, address, write_enable <- loader
// master = host/GPU environment, slave = loader.
interface vram_stream_loader_if;
  import gpu_loader_pkg::*;

  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               write_allow;
  logic [7:0]         data;
  logic [VRAM_AW-1:0] address;
  logic               write_enable;

  modport master (
    output in_data, in_valid, write_allow,
    input  in_ready, data, address, write_enable
  );

  modport slave (
    input  in_data, in_valid, write_allow,
    output in_ready, data, address, write_enable
  );
endinterface

// File: rtl/vram_stream_loader_m_csum.sv
// vram_loader_csum_m: 8-bit running checksum over a packet.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : zero the running sum (packet start)
//   acc_i      : add byte_i to the running sum
//   byte_i     : current accepted byte
//   ok_o       : running sum plus byte_i is zero mod 256
// Built only with VRAM_LOADER_CHECKSUM_EN.
`ifdef VRAM_LOADER_CHECKSUM_EN
module vram_loader_csum_m
  import gpu_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       acc_i,
  input  logic [7:0] byte_i,
  output logic       ok_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i)    sum_d = '0;
    else if (acc_i) sum_d = csum_add(sum_q, byte_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign ok_o = (csum_add(sum_q, byte_i) == 8'h00);

endmodule
`endif

// File: rtl/vram_stream_loader_m.sv
// vram_stream_loader_m: parses framed host packets
//   SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN data bytes [, CSUM]
// and writes each data byte to VRAM one cycle after acceptance.
//   clk, rst_n  : clock, async active-low reset
//   bus (slave) : host stream (in_data/in_valid/in_ready), write_allow,
//                 VRAM write port (data/address/write_enable)
//   busy        : parser not idle
//   packet_done : one-cycle pulse after the final packet byte
//   error       : sticky out-of-range / checksum error, cleared by SYNC
// Optional feature macro: VRAM_LOADER_CHECKSUM_EN (adds trailing CSUM byte).
module vram_stream_loader_m
  import gpu_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vram_stream_loader_if.slave  bus,
  output logic                 busy,
  output logic                 packet_done,
  output logic                 error
);

  state_e             state_q, state_d;
  logic [15:0]        addr_q, addr_d;
  logic [15:0]        len_q, len_d;
  logic [7:0]         data_q, data_d;
  logic [VRAM_AW-1:0] waddr_q, waddr_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               xfer;
  logic [15:0]        len_full;
  logic               cs_ok;

  // Only DATA is throttled by the GPU; held low while reset is asserted.
  assign bus.in_ready = rst_n && ((state_q != S_DATA) || bus.write_allow);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign len_full     = {len_q[15:8], bus.in_data};

`ifdef VRAM_LOADER_CHECKSUM_EN
  logic cs_clear, cs_acc;

  assign cs_clear = xfer && (state_q == S_IDLE) && (bus.in_data == SYNC_BYTE);
  assign cs_acc   = xfer && (state_q != S_IDLE) && (state_q != S_CSUM);

  vram_loader_csum_m u_csum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (cs_clear),
    .acc_i   (cs_acc),
    .byte_i  (bus.in_data),
    .ok_o    (cs_ok)
  );
`else
  assign cs_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    data_d  = data_q;
    waddr_d = waddr_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    if (xfer) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_data == SYNC_BYTE) begin
            state_d = S_ADDR_HI;
            err_d   = 1'b0;
          end
        end
        S_ADDR_HI: begin
          addr_d[15:8] = bus.in_data;
          state_d      = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d[7:0] = bus.in_data;
          state_d     = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d[15:8] = bus.in_data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = len_full;
          if (len_full == 16'd0) begin
`ifdef VRAM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          // Out-of-range bytes are consumed but never reach VRAM.
          if (32'(addr_q) < VRAM_SIZE_C) begin
            we_d    = 1'b1;
            data_d  = bus.in_data;
            waddr_d = addr_q[VRAM_AW-1:0];
          end else begin
            err_d = 1'b1;
          end
          addr_d = addr_q + 16'd1;
          len_d  = len_q - 16'd1;
          if (len_q == 16'd1) begin
`ifdef VRAM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
`ifdef VRAM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!cs_ok) err_d = 1'b1;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.data         = data_q;
  assign bus.address      = waddr_q;
  assign bus.write_enable = we_q;
  assign busy             = (state_q != S_IDLE);
  assign packet_done      = done_q;
  assign error            = err_q;

endmodule
